// File: rtl/lcd_bus_responder_if.sv
// HD44780-style 8-bit LCD bus as seen between the writer and the panel model.
// The writer drives enable/select/data; the panel answers on the read path.
interface lcd_bus_responder_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_en, lcd_rs, lcd_rw, lcd_data_in,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  lcd_en, lcd_rs, lcd_rw, lcd_data_in,
    output lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// On-chip HD44780-style LCD model: decodes bus transactions, keeps a 2x16
// frame buffer, and answers busy/address/data reads.
module lcd_bus_responder #(
  parameter int CMD_CYCLES   = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic               clk,
  input  logic               reset,
  lcd_bus_responder_if.slave bus,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_char,
  output logic [6:0]         cursor_addr,
  output logic               busy,
  output logic               display_on,
  output logic               cursor_on,
  output logic               blink_on,
  output logic               wr_strobe,
  output logic               cmd_error,
  output logic               overrun
);

  localparam int MAXC = (CLEAR_CYCLES > CMD_CYCLES) ?
                        CLEAR_CYCLES : CMD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT} state_e;

  logic          en_s1_q, en_s2_q, en_d_q;
  logic          cap_rs_q, cap_rs_d;
  logic          cap_rw_q, cap_rw_d;
  logic [7:0]    cap_data_q, cap_data_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic [6:0]    addr_q, addr_d;
  logic          id_q, id_d;
  logic          disp_q, disp_d;
  logic          cur_q, cur_d;
  logic          blink_q, blink_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic          cmd_error_q, cmd_error_d;
  logic          overrun_q, overrun_d;
  logic          oe_q, oe_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    rd_char_q, rd_char_d;

  logic [7:0]    mem_q [32];
  logic          mem_we;
  logic [4:0]    mem_idx;
  logic [7:0]    mem_wdata;

  logic          fall;
  logic          go_cmd, go_long, go_clear;
  logic [7:0]    cur_char;
  logic [7:0]    d;

  function automatic logic [6:0] step(input logic [6:0] a,
                                      input logic       inc);
    logic [6:0] r;
    if (inc)
      r = (a == 7'h27) ? 7'h40 :
          (a == 7'h67) ? 7'h00 : a + 7'd1;
    else
      r = (a == 7'h00) ? 7'h67 :
          (a == 7'h40) ? 7'h27 : a - 7'd1;
    return r;
  endfunction

  function automatic logic on_screen(input logic [6:0] a);
    return a[5:4] == 2'b00;
  endfunction

  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  assign fall     = en_d_q & ~en_s2_q;
  assign d        = cap_data_q;
  assign cur_char = on_screen(addr_q) ?
                    mem_q[{addr_q[6], addr_q[3:0]}] : 8'h20;

  always_comb begin
    cap_rs_d    = en_s2_q ? bus.lcd_rs      : cap_rs_q;
    cap_rw_d    = en_s2_q ? bus.lcd_rw      : cap_rw_q;
    cap_data_d  = en_s2_q ? bus.lcd_data_in : cap_data_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    id_d        = id_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    wr_strobe_d = 1'b0;
    cmd_error_d = 1'b0;
    overrun_d   = 1'b0;
    mem_we      = 1'b0;
    mem_idx     = idx_q;
    mem_wdata   = 8'h20;
    go_cmd      = 1'b0;
    go_long     = 1'b0;
    go_clear    = 1'b0;
    rd_char_d   = mem_q[rd_addr];

    // Read drive opens one stage into the synchronizer so data is
    // on the bus two cycles after en rises and drops three after it falls.
    oe_d   = (en_s1_q | en_s2_q) & bus.lcd_rw;
    dout_d = 8'h00;
    if (oe_d)
      dout_d = bus.lcd_rs ? cur_char : {busy_q, addr_q};

    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        idx_d  = idx_q + 5'd1;
        if (cnt_q != '0)
          cnt_d = cnt_q - CW'(1);
        if (idx_q == 5'd31) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase

    if (fall) begin
      if (cap_rw_q) begin
        if (cap_rs_q)
          addr_d = step(addr_q, id_q);
      end else if (busy_q) begin
        overrun_d = 1'b1;
      end else if (cap_rs_q) begin
        if (on_screen(addr_q)) begin
          mem_we      = 1'b1;
          mem_idx     = {addr_q[6], addr_q[3:0]};
          mem_wdata   = d;
          wr_strobe_d = 1'b1;
        end
        addr_d = step(addr_q, id_q);
        go_cmd = 1'b1;
      end else begin
        unique case (1'b1)
          d[7]: begin
            go_cmd = 1'b1;
            if (addr_ok(d[6:0]))
              addr_d = d[6:0];
            else
              cmd_error_d = 1'b1;
          end
          d[7:6] == 2'b01: begin
            go_cmd      = 1'b1;
            cmd_error_d = 1'b1;
          end
          d[7:5] == 3'b001: begin
            go_cmd      = 1'b1;
            cmd_error_d = ~(d[4] & d[3]);
          end
          d[7:4] == 4'b0001: begin
            go_cmd = 1'b1;
            if (!d[3])
              addr_d = step(addr_q, d[2]);
          end
          d[7:3] == 5'b00001: begin
            go_cmd  = 1'b1;
            disp_d  = d[2];
            cur_d   = d[1];
            blink_d = d[0];
          end
          d[7:2] == 6'b000001: begin
            go_cmd = 1'b1;
            id_d   = d[1];
          end
          d[7:1] == 7'b0000001: begin
            go_long = 1'b1;
            addr_d  = 7'h00;
          end
          d == 8'h01: begin
            go_clear = 1'b1;
            addr_d   = 7'h00;
            id_d     = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (go_clear) begin
      state_d = CLEAR;
      idx_d   = 5'd0;
      cnt_d   = CW'(CLEAR_CYCLES - 1);
      busy_d  = 1'b1;
    end else if (go_long) begin
      state_d = WAIT;
      cnt_d   = CW'(CLEAR_CYCLES - 1);
      busy_d  = 1'b1;
    end else if (go_cmd) begin
      state_d = WAIT;
      cnt_d   = CW'(CMD_CYCLES - 1);
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_s1_q     <= 1'b0;
      en_s2_q     <= 1'b0;
      en_d_q      <= 1'b0;
      cap_rs_q    <= 1'b0;
      cap_rw_q    <= 1'b0;
      cap_data_q  <= 8'h00;
      // Power-up behaves like a clear issued on the first edge.
      state_q     <= CLEAR;
      cnt_q       <= CW'(CLEAR_CYCLES);
      idx_q       <= 5'd0;
      busy_q      <= 1'b1;
      addr_q      <= 7'h00;
      id_q        <= 1'b1;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      cmd_error_q <= 1'b0;
      overrun_q   <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= 8'h00;
      rd_char_q   <= 8'h00;
    end else begin
      en_s1_q     <= bus.lcd_en;
      en_s2_q     <= en_s1_q;
      en_d_q      <= en_s2_q;
      cap_rs_q    <= cap_rs_d;
      cap_rw_q    <= cap_rw_d;
      cap_data_q  <= cap_data_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      wr_strobe_q <= wr_strobe_d;
      cmd_error_q <= cmd_error_d;
      overrun_q   <= overrun_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rd_char_q   <= rd_char_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_idx] <= mem_wdata;
  end

  assign bus.lcd_data_out = dout_q;
  assign bus.lcd_data_oe  = oe_q;
  assign rd_char          = rd_char_q;
  assign cursor_addr      = addr_q;
  assign busy             = busy_q;
  assign display_on       = disp_q;
  assign cursor_on        = cur_q;
  assign blink_on         = blink_q;
  assign wr_strobe        = wr_strobe_q;
  assign cmd_error        = cmd_error_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: a table of bus writes with
// hand-computed results plus sequences for reset, clear, reads and overrun.
module tb_lcd_bus_responder;

  localparam int CMD = 40;
  localparam int CLR = 1600;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       busy;
  logic       display_on, cursor_on, blink_on;
  logic       wr_strobe, cmd_error, overrun;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(
    .CMD_CYCLES   (CMD),
    .CLEAR_CYCLES (CLR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .busy        (busy),
    .display_on  (display_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .wr_strobe   (wr_strobe),
    .cmd_error   (cmd_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] addr;
    logic [2:0] flags;
    logic [2:0] ctrl;
    int         bsy;
    int         ridx;
    logic [7:0] rval;
  } vec_t;

  int   total  = 0;
  int   passed = 0;
  logic early_busy;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // One bus transaction; returns at the negedge right after the commit edge.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] din,
                      output logic [7:0] q, output logic [6:0] oe_tr);
    @(negedge clk);
    bus.lcd_rs      = rs;
    bus.lcd_rw      = rw;
    bus.lcd_data_in = din;
    bus.lcd_en      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      oe_tr[i] = bus.lcd_data_oe;
    end
    q = bus.lcd_data_out;
    bus.lcd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      oe_tr[4+i] = bus.lcd_data_oe;
      if (i == 1) early_busy = busy;
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd_chk(input int idx, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = 5'(idx);
    @(negedge clk);
    chk($sformatf("rd_char[%0d]", idx), int'(rd_char), int'(exp));
  endtask

  task automatic blank_chk(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      if (rd_char != 8'h20) begin
        bad++;
        $display("  %s idx %0d holds 0x%0h", tag, i, rd_char);
      end
    end
    chk({tag, " blank cells wrong"}, bad, 0);
  endtask

  vec_t       tbl [25];
  logic [7:0] q;
  logic [6:0] tr;
  int         n;

  initial begin
    tbl[0]  = '{1'b0, 8'h80, 7'h00, 3'b000, 3'b000, CMD, -1, 8'h00};
    tbl[1]  = '{1'b1, 8'h48, 7'h01, 3'b100, 3'b000, CMD, -1, 8'h00};
    tbl[2]  = '{1'b1, 8'h49, 7'h02, 3'b100, 3'b000, CMD,  0, 8'h48};
    tbl[3]  = '{1'b0, 8'hCF, 7'h4F, 3'b000, 3'b000, CMD,  1, 8'h49};
    tbl[4]  = '{1'b1, 8'h41, 7'h50, 3'b100, 3'b000, CMD, 31, 8'h41};
    tbl[5]  = '{1'b1, 8'h42, 7'h51, 3'b000, 3'b000, CMD, 31, 8'h41};
    tbl[6]  = '{1'b0, 8'h04, 7'h51, 3'b000, 3'b000, CMD, -1, 8'h00};
    tbl[7]  = '{1'b0, 8'h80, 7'h00, 3'b000, 3'b000, CMD, -1, 8'h00};
    tbl[8]  = '{1'b1, 8'h5A, 7'h67, 3'b100, 3'b000, CMD,  0, 8'h5A};
    tbl[9]  = '{1'b0, 8'h14, 7'h00, 3'b000, 3'b000, CMD, -1, 8'h00};
    tbl[10] = '{1'b0, 8'h28, 7'h00, 3'b010, 3'b000, CMD, -1, 8'h00};
    tbl[11] = '{1'b0, 8'h38, 7'h00, 3'b000, 3'b000, CMD, -1, 8'h00};
    tbl[12] = '{1'b0, 8'h0E, 7'h00, 3'b000, 3'b110, CMD, -1, 8'h00};
    tbl[13] = '{1'b0, 8'h06, 7'h00, 3'b000, 3'b110, CMD, -1, 8'h00};
    tbl[14] = '{1'b0, 8'hA8, 7'h00, 3'b010, 3'b110, CMD, -1, 8'h00};
    tbl[15] = '{1'b0, 8'hE8, 7'h00, 3'b010, 3'b110, CMD, -1, 8'h00};
    tbl[16] = '{1'b0, 8'hA7, 7'h27, 3'b000, 3'b110, CMD, -1, 8'h00};
    tbl[17] = '{1'b1, 8'h44, 7'h40, 3'b000, 3'b110, CMD,  1, 8'h49};
    tbl[18] = '{1'b0, 8'h10, 7'h27, 3'b000, 3'b110, CMD, -1, 8'h00};
    tbl[19] = '{1'b0, 8'h18, 7'h27, 3'b000, 3'b110, CMD, -1, 8'h00};
    tbl[20] = '{1'b0, 8'h14, 7'h40, 3'b000, 3'b110, CMD, -1, 8'h00};
    tbl[21] = '{1'b0, 8'h40, 7'h40, 3'b010, 3'b110, CMD, -1, 8'h00};
    tbl[22] = '{1'b0, 8'h03, 7'h00, 3'b000, 3'b110, CLR,  0, 8'h5A};
    tbl[23] = '{1'b0, 8'h0D, 7'h00, 3'b000, 3'b101, CMD, -1, 8'h00};
    tbl[24] = '{1'b0, 8'h00, 7'h00, 3'b000, 3'b101,   0, -1, 8'h00};

    reset           = 1'b0;
    rd_addr         = 5'd0;
    bus.lcd_en      = 1'b0;
    bus.lcd_rs      = 1'b0;
    bus.lcd_rw      = 1'b0;
    bus.lcd_data_in = 8'h00;
    early_busy      = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 1);
    chk("reset cursor", int'(cursor_addr), 0);
    chk("reset ctrl", int'({display_on, cursor_on, blink_on}), 0);
    chk("reset pulses", int'({wr_strobe, cmd_error, overrun}), 0);
    chk("reset oe/out", int'({bus.lcd_data_oe, bus.lcd_data_out}), 0);
    chk("reset rd_char", int'(rd_char), 0);

    reset = 1'b1;
    n = 0;
    for (int i = 0; i < CLR + 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("release busy cycles", n, CLR);
    chk("release cursor", int'(cursor_addr), 0);
    blank_chk("release");

    for (int i = 0; i < 25; i++) begin
      xfer(tbl[i].rs, 1'b0, tbl[i].d, q, tr);
      chk($sformatf("v%0d early busy", i), int'(early_busy), 0);
      chk($sformatf("v%0d flags", i),
          int'({wr_strobe, cmd_error, overrun}), int'(tbl[i].flags));
      chk($sformatf("v%0d cursor", i), int'(cursor_addr), int'(tbl[i].addr));
      chk($sformatf("v%0d ctrl", i),
          int'({display_on, cursor_on, blink_on}), int'(tbl[i].ctrl));
      busy_len(n);
      chk($sformatf("v%0d busy cycles", i), n, tbl[i].bsy);
      if (tbl[i].ridx >= 0) rd_chk(tbl[i].ridx, tbl[i].rval);
    end

    // Data read issued while the preceding set-address is still busy.
    xfer(1'b0, 1'b0, 8'h80, q, tr);
    xfer(1'b1, 1'b1, 8'h00, q, tr);
    chk("data read value", int'(q), 8'h5A);
    chk("data read oe trace", int'(tr), 7'b0111110);
    chk("data read no overrun", int'(overrun), 0);
    chk("data read cursor", int'(cursor_addr), 1);
    busy_len(n);
    chk("read idle timeout", int'(n < 5000), 1);

    // Clear with decrement mode set first; clear must restore increment.
    xfer(1'b0, 1'b0, 8'h04, q, tr);
    busy_len(n);
    xfer(1'b0, 1'b0, 8'h01, q, tr);
    chk("clear busy", int'(busy), 1);
    xfer(1'b0, 1'b1, 8'h00, q, tr);
    chk("status read", int'(q), 8'h80);
    chk("status oe trace", int'(tr), 7'b0111110);
    xfer(1'b1, 1'b0, 8'h33, q, tr);
    chk("busy write flags", int'({wr_strobe, cmd_error, overrun}), 3'b001);
    busy_len(n);
    chk("clear idle timeout", int'(n < 5000), 1);
    chk("clear cursor", int'(cursor_addr), 0);
    blank_chk("clear");
    xfer(1'b1, 1'b0, 8'h33, q, tr);
    chk("post-clear strobe", int'(wr_strobe), 1);
    chk("post-clear cursor", int'(cursor_addr), 1);
    busy_len(n);
    rd_chk(0, 8'h33);

    // Reset in the middle of a long busy period.
    xfer(1'b0, 1'b0, 8'h0F, q, tr);
    busy_len(n);
    xfer(1'b0, 1'b0, 8'h03, q, tr);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid reset busy", int'(busy), 1);
    chk("mid reset ctrl", int'({display_on, cursor_on, blink_on}), 0);
    chk("mid reset rd_char", int'(rd_char), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < CLR + 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("re-release busy cycles", n, CLR);
    blank_chk("re-release");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

- Receiving end of the 8-bit HD44780-style LCD bus driven by the game's LCD writer (`lcd_data`, `lcd_en`, `lcd_rs`, `lcd_rw`).
- Decodes instruction and data transactions, keeps a 2x16 character frame buffer, and answers busy-flag, address and data reads.
- Used as an on-chip LCD model for simulation and self-check.
- Also usable as a shadow of the panel contents for a debug/readback path.

## Interface
Parameters:
- CMD_CYCLES, 40: busy duration in clk cycles after any accepted instruction or data write, except clear and home.
- CLEAR_CYCLES, 1600: busy duration after clear display or return home. Must be at least 32.

Ports:
- clk, input, 1: system clock. All logic is single-clock.
- reset, input, 1: asynchronous, active-low reset.
- lcd_en, input, 1: bus enable, asynchronous to clk.
- lcd_rs, input, 1: 0 selects instruction/status, 1 selects data.
- lcd_rw, input, 1: 0 is write, 1 is read.
- lcd_data_in, input, 8: bus data from the writer.
- lcd_data_out, output, 8: read response.
- lcd_data_oe, output, 1: drive enable for lcd_data_out.
- rd_addr, input, 5: frame-buffer readback index, {line, column}.
- rd_char, output, 8: buffer[rd_addr], registered, 1-cycle latency.
- cursor_addr, output, 7: current DDRAM address.
- busy, output, 1: busy flag.
- display_on, cursor_on, blink_on, output, 1 each: display control bits.
- wr_strobe, output, 1: one-cycle pulse per stored data write.
- cmd_error, output, 1: one-cycle pulse for an unsupported or illegal command.
- overrun, output, 1: one-cycle pulse when a write arrives while busy.

## Operation
Bus capture:
- lcd_en passes through a 2-flop synchronizer.
- While synced en=1, rs, rw and data are registered every cycle.
- The falling edge of synced en commits the last captured values as one transaction.

Address map:
- Line 1 is 0x00-0x0F, stored at buffer index {0, addr[3:0]}.
- Line 2 is 0x40-0x4F, stored at buffer index {1, addr[3:0]}.
- 0x10-0x27 and 0x50-0x67 are valid but off-screen: writes are not stored and wr_strobe stays 0, but the address still moves.

Address update after a data write or read:
- Increment (I/D=1): +1, with 0x27 going to 0x40 and 0x67 going to 0x00.
- Decrement (I/D=0): -1, with 0x00 going to 0x67 and 0x40 going to 0x27.

Instructions (rs=0, rw=0), decoded highest set bit first:
- 0x80|a, set DDRAM address:
  - a in 0x00-0x27 or 0x40-0x67 sets cursor_addr=a.
  - Any other a pulses cmd_error and leaves the address unchanged.
- 0x40-0x7F, CGRAM address: not modeled. Pulse cmd_error. Busy CMD_CYCLES.
- 0x20-0x3F, function set:
  - Requires DL=bit4=1 and N=bit3=1.
  - Otherwise pulse cmd_error. No state is held.
- 0x10-0x1F, cursor/display shift:
  - S/C=bit3=0 moves the cursor one step: right if bit2=1, left if bit2=0, using the wrap rules above.
  - S/C=1 is a no-op.
- 0x08-0x0F, display control: display_on=bit2, cursor_on=bit1, blink_on=bit0.
- 0x04-0x07, entry mode: I/D=bit1. The shift bit is ignored.
- 0x02/0x03, return home: cursor_addr=0. Buffer unchanged. Busy CLEAR_CYCLES.
- 0x01, clear: enter CLEAR state.
  - Write 0x20 to indices 0..31, one per cycle.
  - Set cursor_addr=0 and I/D=1.
  - Busy CLEAR_CYCLES.
- 0x00: no-op. Busy is not set.

Data write (rs=1, rw=0):
- Store the byte at the current address if on-screen, pulse wr_strobe, then update the address.

Reads:
- rw=1 is accepted even while busy.
- lcd_data_oe=1 and lcd_data_out is valid while synced en=1 and the captured rw=1. lcd_data_oe=0 otherwise.
- rs=0 read: returns {busy, cursor_addr}.
- rs=1 read: returns the character at cursor_addr, or 0x20 if off-screen. The address updates at en fall.

Writes while busy:
- Any rw=0 transaction while busy=1 is dropped with no state change, and overrun pulses.

State machine, states IDLE, CLEAR and WAIT:
- IDLE: an accepted write goes to WAIT (or CLEAR for 0x01). busy is loaded from the applicable busy counter.
- CLEAR: runs a 5-bit index counter and exits to WAIT after index 31. The busy count runs concurrently from entry.
- WAIT: the counter decrements and the block returns to IDLE at 0.
- busy = (state != IDLE).

## Timing
Reset (while asserted):
- busy=1, cursor_addr=0, I/D=1.
- display_on, cursor_on, blink_on, wr_strobe, cmd_error, overrun, lcd_data_oe all 0.
- lcd_data_out=0x00, rd_char=0x00.

Reset release:
- Enters CLEAR (buffer fill plus CLEAR_CYCLES busy).
- busy falls CLEAR_CYCLES cycles after the first clk edge following release.

Write latency:
- en pin fall to commit is 3 clk edges: 2 sync plus edge detect.
- Buffer write, wr_strobe/cmd_error/overrun pulses and busy rising all occur on the commit edge.

Busy duration:
- busy falls exactly N cycles after commit, where N=CMD_CYCLES or CLEAR_CYCLES.

Read timing:
- lcd_data_oe rises 2 cycles after the en pin rises.
- lcd_data_oe falls 3 cycles after the en pin falls.

Minimum en pulse:
- en high and en low must each last at least 3 clk cycles. Shorter pulses are undefined.

Reset asserted mid-clear or mid-busy:
- Aborts immediately. Clear restarts from index 0 on release.

## Test plan
- Reset release: busy=1 for CLEAR_CYCLES. Afterwards rd_char=0x20 for all rd_addr 0..31, and cursor_addr=0x00.
- Write 0x80, 0x48, 0x49: rd_char[0]=0x48, rd_char[1]=0x49, cursor_addr=0x02, two wr_strobe pulses.
- Write 0xCF then 0x41: rd_char[31]=0x41 and cursor_addr=0x50. Then write 0x42: no wr_strobe, buffer unchanged, cursor_addr=0x51.
- Write 0x04, 0x80, 0x5A: rd_char[0]=0x5A, cursor_addr=0x67. Then write 0x14: cursor_addr=0x00.
- Write 0x01, then immediately a status read: lcd_data_out=0x80. Then data write 0x33 while busy: overrun=1, buffer all 0x20.
- Write 0x28: cmd_error pulse. Write 0x38: no cmd_error. Write 0x0E: display_on=1, cursor_on=1, blink_on=0.
